// File: rtl/ub_access_scheduler_pkg.sv
// Shared types for the unified-buffer access scheduler: requester IDs, read tags,
// feed FSM states and the round-robin pick helpers.
package ub_access_scheduler_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_HOST = 2'd1,
    TAG_FEED = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_RUN   = 2'd1,
    FEED_DRAIN = 2'd2
  } feed_state_e;

  localparam logic [1:0] REQ_WB   = 2'd0;
  localparam logic [1:0] REQ_HOST = 2'd1;
  localparam logic [1:0] REQ_FEED = 2'd2;

  // One-hot grant: first eligible requester found scanning upward from ptr.
  function automatic logic [2:0] rr_grant(input logic [2:0] elig, input logic [1:0] ptr);
    logic [2:0] g;
    logic       found;
    logic [1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idx = 2'((int'(ptr) + i) % 3);
      if (!found && elig[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [1:0] rr_next(input logic [2:0] g, input logic [1:0] ptr);
    if (g[REQ_WB])   return REQ_HOST;
    if (g[REQ_HOST]) return REQ_FEED;
    if (g[REQ_FEED]) return REQ_WB;
    return ptr;
  endfunction

endpackage

// File: rtl/ub_access_scheduler_skid.sv
// Two-entry in-order FIFO holding feed words returned by the buffer until the
// array accepts them; simultaneous push and pop allowed.
module ub_access_scheduler_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) wr_q <= ~wr_q;
      if (pop_i)  rd_q <= ~rd_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/ub_access_scheduler.sv
// Shares the single-port unified buffer among writeback, host MMIO and the burst
// feed reader with round-robin arbitration and a registered read-return tag.
//
//  state      | meaning
//  FEED_IDLE  | no burst; feed_start sampled
//  FEED_RUN   | issuing burst reads while credit allows
//  FEED_DRAIN | all reads issued; waiting for the last word to be accepted
module ub_access_scheduler
  import ub_access_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  feed_start,
  input  logic [ADDR_WIDTH-1:0] feed_base,
  input  logic [LEN_WIDTH-1:0]  feed_len,
  output logic                  feed_busy,
  output logic                  feed_done,
  output logic                  feed_valid,
  output logic [DATA_WIDTH-1:0] feed_data,
  input  logic                  feed_ready,
  output logic                  ub_we,
  output logic [ADDR_WIDTH-1:0] ub_addr,
  output logic [DATA_WIDTH-1:0] ub_din,
  input  logic [DATA_WIDTH-1:0] ub_dout
);

  feed_state_e           state_q, state_d;
  tag_e                  tag_q, tag_d;
  logic [1:0]            rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] feed_addr_q, feed_addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  zero_done_q, zero_done_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_pop;
  logic                  inflight;
  logic [2:0]            credit_used;
  logic                  feed_issue_ok;
  logic [2:0]            elig;
  logic [2:0]            grant;
  logic                  done_hs;

  assign inflight   = (tag_q == TAG_FEED);
  assign feed_valid = (fifo_count != 2'd0);
  assign fifo_pop   = feed_valid & feed_ready;

  // A word popped this cycle frees its slot in time for the read issued now.
  assign credit_used   = {1'b0, fifo_count} + 3'(inflight) - 3'(fifo_pop);
  assign feed_issue_ok = (state_q == FEED_RUN) && (credit_used < 3'd2);

  // Gating with rst_n keeps every output at zero while reset is held.
  assign elig  = {feed_issue_ok, host_req, wb_valid} & {3{rst_n}};
  assign grant = rr_grant(elig, rr_q);
  assign rr_d  = rr_next(grant, rr_q);

  assign wb_ready = grant[REQ_WB];
  assign host_gnt = grant[REQ_HOST];
  assign ub_we    = grant[REQ_WB] | (grant[REQ_HOST] & host_we);

  always_comb begin
    ub_addr = addr_q;
    ub_din  = '0;
    tag_d   = TAG_NONE;
    if (grant[REQ_WB]) begin
      ub_addr = wb_addr;
      ub_din  = wb_data;
    end else if (grant[REQ_HOST]) begin
      ub_addr = host_addr;
      if (host_we) ub_din = host_wdata;
      else         tag_d  = TAG_HOST;
    end else if (grant[REQ_FEED]) begin
      ub_addr = feed_addr_q;
      tag_d   = TAG_FEED;
    end
  end

  assign host_rvalid = (tag_q == TAG_HOST);
  assign host_rdata  = host_rvalid ? ub_dout : '0;
  assign feed_data   = feed_valid ? fifo_dout : '0;
  assign feed_busy   = (state_q != FEED_IDLE);

  assign done_hs   = (state_q == FEED_DRAIN) && fifo_pop && (fifo_count == 2'd1) && !inflight;
  assign feed_done = done_hs | zero_done_q;

  ub_access_scheduler_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight),
    .din_i   (ub_dout),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    feed_addr_d = feed_addr_q;
    remain_d    = remain_q;
    zero_done_d = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (feed_start) begin
          if (feed_len != '0) begin
            state_d     = FEED_RUN;
            feed_addr_d = feed_base;
            remain_d    = feed_len;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      FEED_RUN: begin
        if (grant[REQ_FEED]) begin
          feed_addr_d = feed_addr_q + ADDR_WIDTH'(1);
          remain_d    = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) state_d = FEED_DRAIN;
        end
      end
      FEED_DRAIN: begin
        if (done_hs || (fifo_count == 2'd0 && !inflight)) state_d = FEED_IDLE;
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FEED_IDLE;
      tag_q       <= TAG_NONE;
      rr_q        <= REQ_WB;
      feed_addr_q <= '0;
      remain_q    <= '0;
      zero_done_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      rr_q        <= rr_d;
      feed_addr_q <= feed_addr_d;
      remain_q    <= remain_d;
      zero_done_q <= zero_done_d;
      addr_q      <= ub_addr;
    end
  end

endmodule

// File: tb/tb_ub_access_scheduler.sv
// Directed plus randomized bench for ub_access_scheduler with a behavioural buffer
// and a transaction-level reference model (memory image, feed queue, busy flag).
module tb_ub_access_scheduler;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          feed_start, feed_busy, feed_done, feed_valid, feed_ready;
  logic [AW-1:0] feed_base;
  logic [LW-1:0] feed_len;
  logic [DW-1:0] feed_data;
  logic          ub_we;
  logic [AW-1:0] ub_addr;
  logic [DW-1:0] ub_din, ub_dout;

  always #5 clk = ~clk;

  ub_access_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .feed_start(feed_start), .feed_base(feed_base), .feed_len(feed_len),
    .feed_busy(feed_busy), .feed_done(feed_done), .feed_valid(feed_valid),
    .feed_data(feed_data), .feed_ready(feed_ready),
    .ub_we(ub_we), .ub_addr(ub_addr), .ub_din(ub_din), .ub_dout(ub_dout)
  );

  // Single-port buffer with registered read.
  logic [DW-1:0] ub_mem [16];
  always @(posedge clk) begin
    if (ub_we) ub_mem[ub_addr] <= ub_din;
    ub_dout <= ub_mem[ub_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] feed_q [$];
  logic          host_pend = 1'b0;
  logic [DW-1:0] host_exp;
  logic          model_busy = 1'b0;
  logic          zero_pend = 1'b0;
  int            wb_wait = 0, host_wait = 0, cyc = 0;
  logic          saw_wb, saw_host, saw_done, last_rvalid, last_hs, last_fvalid, last_ub_we;
  logic [DW-1:0] last_rdata, last_fdata;
  logic [AW-1:0] last_ub_addr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, update the model, return just after the rising edge.
  task automatic cycle();
    logic busy_now, exp_done, hs;
    @(negedge clk);
    cyc++;
    saw_wb = wb_ready; saw_host = host_gnt; saw_done = feed_done;
    last_rvalid = host_rvalid; last_rdata = host_rdata;
    last_fvalid = feed_valid; last_fdata = feed_data;
    last_ub_we = ub_we; last_ub_addr = ub_addr;
    busy_now = model_busy;
    chk("busy", feed_busy, model_busy);
    chk("rvalid", host_rvalid, host_pend);
    if (host_pend) chk("rdata", host_rdata, host_exp);
    host_pend = 1'b0;
    chk("single_grant", wb_ready & host_gnt, 0);
    chk("ub_we", ub_we, wb_ready | (host_gnt & host_we));
    if (wb_ready) begin
      chk("wb_addr", ub_addr, wb_addr);
      chk("wb_din", ub_din, wb_data);
      ref_mem[wb_addr] = wb_data;
    end
    if (host_gnt) begin
      chk("host_addr", ub_addr, host_addr);
      if (host_we) begin
        chk("host_din", ub_din, host_wdata);
        ref_mem[host_addr] = host_wdata;
      end else begin
        host_pend = 1'b1;
        host_exp  = ref_mem[host_addr];
      end
    end
    hs = feed_valid & feed_ready;
    last_hs = hs;
    exp_done = zero_pend;
    zero_pend = 1'b0;
    if (hs) begin
      chk("feed_nonempty", feed_q.size() != 0, 1);
      if (feed_q.size() != 0) begin
        chk("feed_data", feed_data, feed_q.pop_front());
        if (feed_q.size() == 0) begin
          exp_done = 1'b1;
          model_busy = 1'b0;
        end
      end
    end
    chk("feed_done", feed_done, exp_done);
    if (feed_start && !busy_now) begin
      if (feed_len == '0) zero_pend = 1'b1;
      else begin
        model_busy = 1'b1;
        for (int i = 0; i < int'(feed_len); i++)
          feed_q.push_back(ref_mem[AW'(int'(feed_base) + i)]);
      end
    end
    if (wb_valid && !wb_ready) wb_wait++; else wb_wait = 0;
    if (host_req && !host_gnt) host_wait++; else host_wait = 0;
    if (wb_valid)  chk("wb_wait", wb_wait <= 2, 1);
    if (host_req)  chk("host_wait", host_wait <= 2, 1);
    @(posedge clk);
    #1;
  endtask

  // Keep requests held until granted; afterwards pick a new (or forced) request.
  task automatic drive_reqs(input bit force_all);
    if (saw_wb || !wb_valid) begin
      wb_valid = force_all ? 1'b1 : 1'($urandom_range(0, 1));
      wb_addr  = AW'(8 + $urandom_range(0, 7));
      wb_data  = $urandom;
    end
    if (saw_host || !host_req) begin
      host_req   = force_all ? 1'b1 : 1'($urandom_range(0, 1));
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = host_we ? AW'(8 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
      host_wdata = $urandom;
    end
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (saw_host) break;
    end
    chk("host_op_gnt", saw_host, 1);
    host_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && (model_busy || zero_pend || host_pend); k++) cycle();
    chk(tag, model_busy | zero_pend | host_pend, 0);
  endtask

  initial begin
    int n, first_hs, done_cyc, prev_code, code;
    logic [AW-1:0] feed_ptr;
    rst_n = 1'b0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    feed_start = 0; feed_base = '0; feed_len = '0; feed_ready = 0;
    saw_wb = 0; saw_host = 0;
    #12;
    chk("rst_outputs", |{wb_ready, host_gnt, host_rvalid, host_rdata, feed_busy, feed_done,
                          feed_valid, feed_data, ub_we, ub_addr, ub_din}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // 1: host write then read back
    host_op(1'b1, 4'd3, 32'hDEADBEEF);
    host_op(1'b0, 4'd3, '0);
    cycle();
    chk("t1_rvalid", last_rvalid, 1);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);

    // 2: preload, wrapping burst with ready held high
    for (int i = 0; i < 16; i++) host_op(1'b1, AW'(i), 32'h10 + i);
    feed_ready = 1'b1;
    feed_start = 1'b1; feed_base = 4'd14; feed_len = 5'd4;
    cycle();
    feed_start = 1'b0;
    n = 0; first_hs = -1; done_cyc = -1;
    for (int k = 0; k < 20 && model_busy; k++) begin
      cycle();
      if (last_hs) begin
        if (first_hs < 0) first_hs = cyc;
        chk("t2_data", last_fdata, 32'h10 + ((14 + n) % 16));
        n++;
      end
      if (saw_done) done_cyc = cyc;
    end
    chk("t2_words", n, 4);
    chk("t2_gapless", done_cyc - first_hs, 3);
    cycle();
    chk("t2_busy_drop", feed_busy, 0);

    // 3: same burst, consumer stalls mid-burst
    feed_start = 1'b1; feed_base = 4'd14; feed_len = 5'd4;
    cycle();
    feed_start = 1'b0;
    cycle(); cycle(); cycle();
    feed_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_stall_valid", last_fvalid, 1);
    end
    feed_ready = 1'b1;
    wait_idle("t3_finish");

    // 4: all three requesters contending -> strict rotation
    prev_code = 0; feed_ptr = '0;
    for (int k = 0; k < 12; k++) begin
      drive_reqs(1'b1);
      if (k == 0) begin feed_start = 1'b1; feed_base = '0; feed_len = 5'd8; end
      cycle();
      feed_start = 1'b0;
      code = saw_wb ? 0 : (saw_host ? 1 : 2);
      if (k > 0) chk("t4_rotate", code, (prev_code + 1) % 3);
      if (code == 2) begin
        chk("t4_feed_addr", last_ub_addr, feed_ptr);
        feed_ptr = feed_ptr + 1'b1;
      end
      prev_code = code;
    end
    wb_valid = 0; host_req = 0;
    wait_idle("t4_finish");

    // 5: zero-length burst
    feed_start = 1'b1; feed_base = 4'd5; feed_len = '0;
    cycle();
    feed_start = 1'b0;
    cycle();
    chk("t5_done", saw_done, 1);
    chk("t5_no_write", last_ub_we, 0);
    cycle();
    chk("t5_done_pulse", saw_done, 0);

    // 6: reset mid-burst, then a fresh burst
    feed_start = 1'b1; feed_base = 4'd4; feed_len = 5'd6;
    cycle();
    feed_start = 1'b0;
    cycle(); cycle();
    wb_valid = 1'b1; host_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs", |{wb_ready, host_gnt, host_rvalid, host_rdata, feed_busy, feed_done,
                             feed_valid, feed_data, ub_we, ub_addr, ub_din}, 0);
    feed_q.delete();
    model_busy = 0; zero_pend = 0; host_pend = 0; wb_wait = 0; host_wait = 0;
    @(posedge clk); @(posedge clk); #1;
    wb_valid = 1'b0; host_req = 1'b0;
    rst_n = 1'b1;
    feed_start = 1'b1; feed_base = '0; feed_len = 5'd3;
    cycle();
    feed_start = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && model_busy; k++) begin
      cycle();
      if (last_hs) begin
        chk("t6_data", last_fdata, 32'h10 + n);
        n++;
      end
    end
    chk("t6_words", n, 3);

    // Random traffic: bursts read 0..7, writes land in 8..15
    saw_wb = 0; saw_host = 0;
    for (int k = 0; k < 500; k++) begin
      drive_reqs(1'b0);
      feed_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        feed_start = 1'b1;
        feed_base  = AW'($urandom_range(0, 7));
        feed_len   = LW'($urandom_range(0, 8 - int'(feed_base)));
      end
      cycle();
      feed_start = 1'b0;
    end
    wb_valid = 0; host_req = 0; feed_ready = 1'b1;
    wait_idle("rand_finish");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
